instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Holds the architectural PC register and fetches the instruction word at PC from instruction memory.
//  Sits directly downstream of the PC-next logic:
//   - pc_next/pc_en come from the PC control block.
//   - instr goes to decode.
//  The stage sequencer pulses fetch_start in STAGE_FETCH and waits for fetch_done before advancing.
//  Memory access uses a req/ack handshake, so multi-cycle memories are supported.
// PARAMETERS
//  RESET_VECTOR    32'h0000_0000  PC value after reset
//  TIMEOUT_CYCLES  255            max cycles waiting for mem_ack before bus fault (1..255)
//  NOP_INSTR       32'h0000_0013  instr value after reset/fault (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  fetch_start  in   1   one-cycle request from stage sequencer to fetch at pc
//  pc_next      in   32  next PC from PC control
//  pc_en        in   1   load pc_next into pc this edge
//  mem_addr     out  32  instruction memory address (= pc, word aligned)
//  mem_req      out  1   memory request, held until mem_ack
//  mem_ack      in   1   memory has valid mem_rdata this cycle
//  mem_rdata    in   32  instruction word from memory
//  pc           out  32  current architectural PC
//  instr        out  32  last successfully fetched instruction
//  fetch_done   out  1   one-cycle pulse: fetch finished (success or fault)
//  fetch_busy   out  1   FSM not in IDLE
//  fault        out  1   held with/after fetch_done: 1 = last fetch faulted
//  fault_cause  out  2   00 none, 01 misaligned pc, 10 bus timeout
//  proto_err    out  1   sticky: pc_en or fetch_start arrived while busy
// BEHAVIOUR
//  Reset (async, any state)
//   - pc = RESET_VECTOR, instr = NOP_INSTR, FSM = IDLE.
//   - mem_req, fetch_done, fault, proto_err = 0; fault_cause = 00; timeout counter = 0.
//  PC register
//   - pc <= pc_next on a clk edge with pc_en=1 and FSM in IDLE; other states ignore pc_en.
//   - No alignment check at load; the check is done at fetch.
//  FSM: IDLE -> REQ -> DONE -> IDLE
//   - IDLE: fetch_start=1 and pc[1:0]!=0 -> DONE; fault=1, cause 01; no mem_req.
//   - IDLE: fetch_start=1 and pc aligned -> REQ; counter cleared.
//   - REQ: mem_req=1, mem_addr=pc.
//     - mem_ack=1 -> DONE; instr <= mem_rdata; fault=0, cause 00.
//     - Ack in the first REQ cycle is legal (fetch latency = 2 cycles start->done).
//   - REQ, no ack: counter increments; counter==TIMEOUT_CYCLES-1 with no ack -> DONE.
//     - On timeout: fault=1, cause 10, instr <= NOP_INSTR, mem_req drops.
//   - DONE: fetch_done=1 for exactly one cycle, then IDLE.
//   - fault/fault_cause hold until the next fetch_start is accepted.
//  mem_addr = pc in every state; it is only meaningful while mem_req=1.
//  pc_en and fetch_start in the same IDLE cycle:
//   - pc loads pc_next; the fetch uses the OLD pc (registered value).
//   - The sequencer must not do this; proto_err is not set.
//  fetch_start or pc_en in REQ/DONE: ignored; proto_err <= 1 (sticky until reset).
//  mem_ack in IDLE/DONE: ignored.
//  Reset asserted mid-REQ: mem_req drops immediately (async); the outstanding ack is discarded.
// STRUCTURE
//  arch_defines.v (shared):
//   - FETCH_IDLE/REQ/DONE state encodings (2 bit)
//   - FAULT_NONE/MISALIGNED/TIMEOUT codes
//   - RISCV_NOP constant
//  Single module, no sub-modules; timeout counter is 8 bit, inline.
// TESTING
//  1 Reset -> pc=RESET_VECTOR, instr=32'h13, mem_req=0, fetch_done=0, proto_err=0.
//  2 fetch_start at pc=0x0, ack in first REQ cycle with rdata=0x00500093
//    -> done 2 cycles after start, instr=0x00500093, fault=0.
//  3 pc_en with pc_next=0x104, then fetch_start, ack after 5 wait cycles
//    -> mem_addr=0x104 throughout, mem_req high 6 cycles, one fetch_done pulse.
//  4 pc_next=0x102 loaded, fetch_start -> no mem_req, fetch_done next cycle, fault=1, cause=01.
//  5 TIMEOUT_CYCLES=4, never ack -> mem_req high 4 cycles, fault=1, cause=10, instr=0x13.
//  6 pc_en pulse during REQ -> pc unchanged, proto_err=1 and stays 1;
//    then async reset mid-REQ -> mem_req=0 without waiting for a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage:
// FSM state encodings, fault cause codes and the canonical RISC-V NOP.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_DONE = 2'b10
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGNED = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT    = 2'b10;

    localparam logic [31:0] RISCV_NOP = 32'h0000_0013;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Architectural PC register plus a req/ack instruction fetch FSM with
// misalignment and bus-timeout fault reporting.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NOP_INSTR      = RISCV_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] pc_next,
    input  logic        pc_en,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        fetch_done,
    output logic        fetch_busy,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        proto_err
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         fault_q, fault_d;
    logic [1:0]   cause_q, cause_d;
    logic         proto_q, proto_d;
    logic         req_q;
    logic         done_q;
    logic         busy_q;

    // Next-state, PC load, fetch result and protocol-error logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        cause_d = cause_q;
        proto_d = proto_q;
        case (state_q)
            FETCH_IDLE: begin
                if (pc_en) begin
                    pc_d = pc_next;
                end else begin
                    pc_d = pc_q;
                end
                // Alignment is judged on the registered PC, even if pc_en loads a new one
                if (fetch_start) begin
                    if (pc_misaligned(pc_q)) begin
                        state_d = FETCH_DONE;
                        fault_d = 1'b1;
                        cause_d = FAULT_MISALIGNED;
                    end else begin
                        state_d = FETCH_REQ;
                        cnt_d   = 8'd0;
                        fault_d = 1'b0;
                        cause_d = FAULT_NONE;
                    end
                end else begin
                    state_d = FETCH_IDLE;
                end
            end
            FETCH_REQ: begin
                if (fetch_start || pc_en) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
                if (mem_ack) begin
                    state_d = FETCH_DONE;
                    instr_d = mem_rdata;
                    fault_d = 1'b0;
                    cause_d = FAULT_NONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = FETCH_DONE;
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                    cause_d = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FETCH_DONE: begin
                if (fetch_start || pc_en) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
                state_d = FETCH_IDLE;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake outputs are registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= NOP_INSTR;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            cause_q <= FAULT_NONE;
            proto_q <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            proto_q <= proto_d;
            req_q   <= (state_d == FETCH_REQ);
            done_q  <= (state_d == FETCH_DONE);
            busy_q  <= (state_d != FETCH_IDLE);
        end
    end

    assign mem_addr    = pc_q;
    assign mem_req     = req_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign fetch_done  = done_q;
    assign fetch_busy  = busy_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign proto_err   = proto_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard-driven bench for instr_fetch_unit: a default-timeout instance for
// the main scenarios and a TIMEOUT_CYCLES=4 instance for the bus-timeout case.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_main, fs_to, pc_en, mem_ack;
    logic [31:0] pc_next, mem_rdata;

    logic [31:0] mem_addr, pc, instr;
    logic        mem_req, fetch_done, fetch_busy, fault, proto_err;
    logic [1:0]  fault_cause;

    logic [31:0] mem_addr_t, pc_t, instr_t;
    logic        mem_req_t, fetch_done_t, fetch_busy_t, fault_t, proto_err_t;
    logic [1:0]  fault_cause_t;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        logic [1:0]  cause;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_instr;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_start(fs_main), .pc_next(pc_next), .pc_en(pc_en),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc), .instr(instr), .fetch_done(fetch_done), .fetch_busy(fetch_busy),
        .fault(fault), .fault_cause(fault_cause), .proto_err(proto_err)
    );

    instr_fetch_unit #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset), .fetch_start(fs_to), .pc_next(pc_next), .pc_en(pc_en),
        .mem_addr(mem_addr_t), .mem_req(mem_req_t), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc(pc_t), .instr(instr_t), .fetch_done(fetch_done_t), .fetch_busy(fetch_busy_t),
        .fault(fault_t), .fault_cause(fault_cause_t), .proto_err(proto_err_t)
    );

    // Scoreboard: every fetch_done pulse of the main instance retires one expected result
    always @(negedge clk) begin
        if (!reset && fetch_done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got fetch_done=1, required no pending fetch");
            end else begin
                sb_e = sb_q.pop_front();
                if ({instr, fault, fault_cause} !== {sb_e.instr, sb_e.fault, sb_e.cause}) begin
                    errors++;
                    $display("FAIL sb_result: got instr=%h fault=%b cause=%b, required instr=%h fault=%b cause=%b",
                             instr, fault, fault_cause, sb_e.instr, sb_e.fault, sb_e.cause);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] i, input logic f, input logic [1:0] c);
        exp_t e;
        e.instr = i;
        e.fault = f;
        e.cause = c;
        sb_q.push_back(e);
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_en   = 1'b1;
        pc_next = v;
        tick();
        pc_en   = 1'b0;
    endtask

    // waits < 0 means never acknowledge; first_done counts edges after the start edge
    task automatic run_fetch(input int waits, input logic [31:0] rdata, input logic [31:0] addr_exp,
                             output int req_cyc, output int done_cyc, output int addr_bad,
                             output int first_done, output int finished);
        req_cyc = 0; done_cyc = 0; addr_bad = 0; first_done = -1; finished = 0;
        fs_main = 1'b1;
        tick();
        fs_main = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                req_cyc++;
                if (mem_addr !== addr_exp) addr_bad++;
                if (waits >= 0 && req_cyc == waits + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (fetch_done === 1'b1) begin
                done_cyc++;
                if (first_done < 0) first_done = c;
            end
            if (fetch_busy === 1'b0 && fetch_done === 1'b0) begin
                finished = 1;
                break;
            end
            tick();
        end
        mem_ack = 1'b0;
        checks++;
        if (finished != 1) begin
            errors++;
            $display("FAIL fetch_bound: got fetch still busy after 40 cycles, required return to idle");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fs_main = 1'b0; fs_to = 1'b0; pc_en = 1'b0; mem_ack = 1'b0;
        pc_next = 32'h0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (pc !== 32'h0000_0000) begin errors++; $display("FAIL reset_pc: got %h, required 00000000", pc); end
        checks++;
        if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h, required 00000013", instr); end
        checks++;
        if ({mem_req, fetch_done, fetch_busy, proto_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got req/done/busy/perr=%b%b%b%b, required 0000", mem_req, fetch_done, fetch_busy, proto_err);
        end
        checks++;
        if ({fault, fault_cause} !== 3'b000) begin
            errors++;
            $display("FAIL reset_fault: got fault=%b cause=%b, required 0 00", fault, fault_cause);
        end
        last_instr = 32'h0000_0013;
    endtask

    task automatic test_basic_fetch();
        int rq, dn, ab, fd, fin;
        push_exp(32'h0050_0093, 1'b0, 2'b00);
        run_fetch(0, 32'h0050_0093, 32'h0000_0000, rq, dn, ab, fd, fin);
        last_instr = 32'h0050_0093;
        checks++;
        if (fd !== 2) begin errors++; $display("FAIL basic_latency: got done at cycle %0d, required 2", fd); end
        checks++;
        if (rq !== 1 || dn !== 1) begin errors++; $display("FAIL basic_counts: got req=%0d done=%0d, required 1 1", rq, dn); end
        checks++;
        if (instr !== 32'h0050_0093 || fault !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got instr=%h fault=%b, required 00500093 0", instr, fault);
        end
    endtask

    task automatic test_wait_states();
        int rq, dn, ab, fd, fin;
        load_pc(32'h0000_0104);
        checks++;
        if (pc !== 32'h0000_0104) begin errors++; $display("FAIL ws_pc_load: got %h, required 00000104", pc); end
        push_exp(32'h1234_5678, 1'b0, 2'b00);
        run_fetch(5, 32'h1234_5678, 32'h0000_0104, rq, dn, ab, fd, fin);
        last_instr = 32'h1234_5678;
        checks++;
        if (rq !== 6) begin errors++; $display("FAIL ws_req_cycles: got %0d, required 6", rq); end
        checks++;
        if (ab !== 0) begin errors++; $display("FAIL ws_addr: got %0d bad cycles, required 0", ab); end
        checks++;
        if (dn !== 1 || fd !== 7) begin errors++; $display("FAIL ws_done: got pulses=%0d at %0d, required 1 at 7", dn, fd); end
    endtask

    task automatic test_misaligned();
        int rq, dn, ab, fd, fin;
        load_pc(32'h0000_0102);
        push_exp(last_instr, 1'b1, 2'b01);
        run_fetch(0, 32'hFFFF_FFFF, 32'h0000_0102, rq, dn, ab, fd, fin);
        checks++;
        if (rq !== 0) begin errors++; $display("FAIL mis_no_req: got %0d req cycles, required 0", rq); end
        checks++;
        if (dn !== 1 || fd !== 1) begin errors++; $display("FAIL mis_done: got pulses=%0d at %0d, required 1 at 1", dn, fd); end
    endtask

    task automatic test_back_to_back();
        int rq, dn, ab, fd, fin;
        load_pc(32'h0000_0008);
        checks++;
        if ({fault, fault_cause} !== 3'b101) begin
            errors++;
            $display("FAIL b2b_fault_hold: got fault=%b cause=%b, required 1 01", fault, fault_cause);
        end
        push_exp(32'h00A0_0113, 1'b0, 2'b00);
        run_fetch(1, 32'h00A0_0113, 32'h0000_0008, rq, dn, ab, fd, fin);
        checks++;
        if (rq !== 2 || fd !== 3) begin errors++; $display("FAIL b2b_first: got req=%0d done_at=%0d, required 2 3", rq, fd); end
        push_exp(32'hDEAD_BEEF, 1'b0, 2'b00);
        run_fetch(0, 32'hDEAD_BEEF, 32'h0000_0008, rq, dn, ab, fd, fin);
        last_instr = 32'hDEAD_BEEF;
        checks++;
        if (rq !== 1 || dn !== 1) begin errors++; $display("FAIL b2b_second: got req=%0d done=%0d, required 1 1", rq, dn); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        tick();
        mem_ack = 1'b0;
        checks++;
        if (instr !== last_instr || fetch_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got instr=%h done=%b, required %h 0", instr, fetch_done, last_instr);
        end
    endtask

    task automatic test_timeout();
        int rq = 0;
        int dn = 0;
        load_pc(32'h0000_0200);
        fs_to = 1'b1;
        tick();
        fs_to = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (mem_req_t === 1'b1) rq++;
            if (fetch_done_t === 1'b1) dn++;
            if (fetch_busy_t === 1'b0) break;
            tick();
        end
        checks++;
        if (rq !== 4) begin errors++; $display("FAIL to_req_cycles: got %0d, required 4", rq); end
        checks++;
        if (dn !== 1) begin errors++; $display("FAIL to_done_pulses: got %0d, required 1", dn); end
        checks++;
        if ({fault_t, fault_cause_t} !== 3'b110 || instr_t !== 32'h0000_0013) begin
            errors++;
            $display("FAIL to_result: got fault=%b cause=%b instr=%h, required 1 10 00000013", fault_t, fault_cause_t, instr_t);
        end
    endtask

    task automatic test_proto_and_async_reset();
        fs_main = 1'b1;
        tick();
        fs_main = 1'b0;
        pc_en   = 1'b1;
        pc_next = 32'h0000_0300;
        tick();
        pc_en = 1'b0;
        checks++;
        if (pc !== 32'h0000_0200) begin errors++; $display("FAIL perr_pc_hold: got %h, required 00000200", pc); end
        repeat (3) tick();
        checks++;
        if (proto_err !== 1'b1 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL perr_sticky: got perr=%b req=%b, required 1 1", proto_err, mem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL async_req_drop: got %b, required 0", mem_req); end
        tick();
        reset   = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        tick();
        checks++;
        if (instr !== 32'h0000_0013 || proto_err !== 1'b0 || fetch_busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got instr=%h perr=%b busy=%b, required 00000013 0 0", instr, proto_err, fetch_busy);
        end
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_misaligned();
        test_back_to_back();
        test_timeout();
        test_proto_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
